universal_shift_reg: RTL and testbench



---
 rtl/usr_pkg.sv | 14 +
 rtl/usr_bit_cell.sv | 44 ++++
 rtl/universal_shift_reg.sv | 60 ++++++
 tb/tb_universal_shift_reg.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// ============================================================================
// usr_pkg : mode encodings shared by the universal shift register and its cells
// Revision: 1.0
// ============================================================================
`default_nettype none

package usr_pkg;
  localparam logic [1:0] USR_HOLD = 2'd0;
  localparam logic [1:0] USR_SHR  = 2'd1;
  localparam logic [1:0] USR_SHL  = 2'd2;
  localparam logic [1:0] USR_LOAD = 2'd3;
endpackage

`default_nettype wire

// File: rtl/usr_bit_cell.sv
// ============================================================================
// usr_bit_cell : one register stage, 4:1 mux over self / neighbours / load bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module usr_bit_cell
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] sel,
  input  logic       hi_nbr,
  input  logic       lo_nbr,
  input  logic       par_bit,
  output logic       q
);

  logic d;

  // hi_nbr feeds a right shift (data moves toward bit 0), lo_nbr a left shift
  always_comb begin
    d = q;
    case (sel)
      USR_HOLD: d = q;
      USR_SHR:  d = hi_nbr;
      USR_SHL:  d = lo_nbr;
      USR_LOAD: d = par_bit;
      default:  d = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/universal_shift_reg.sv
// ============================================================================
// universal_shift_reg : hold / shift right / shift left / load register.
// Optional clock enable port ce when USR_CE_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module universal_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef USR_CE_EN
  input  logic             ce,
`endif
  input  logic             ser_inl,
  input  logic             ser_inr,
  input  logic [WIDTH-1:0] par_in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_outr,
  output logic             ser_outl
);

  logic             en;
  logic [WIDTH-1:0] q;
  logic [WIDTH+1:0] ext;

`ifdef USR_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  // Padding the register with the serial inputs lets every cell use the same
  // neighbour indexing, including the two boundary cells.
  assign ext = {ser_inr, q, ser_inl};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      usr_bit_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sel     (sel),
        .hi_nbr  (ext[i+2]),
        .lo_nbr  (ext[i]),
        .par_bit (par_in[i]),
        .q       (q[i])
      );
    end
  endgenerate

  assign par_out  = q;
  assign ser_outr = q[0];
  assign ser_outl = q[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// ============================================================================
// tb_universal_shift_reg : scoreboard bench for universal_shift_reg (WIDTH=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ce  = 1'b1;
  logic             ser_inl = 1'b0;
  logic             ser_inr = 1'b0;
  logic [WIDTH-1:0] par_in = '0;
  logic [1:0]       sel = USR_HOLD;
  logic [WIDTH-1:0] par_out;
  logic             ser_outr;
  logic             ser_outl;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef USR_CE_EN
    .ce       (ce),
`endif
    .ser_inl  (ser_inl),
    .ser_inr  (ser_inr),
    .par_in   (par_in),
    .sel      (sel),
    .par_out  (par_out),
    .ser_outr (ser_outr),
    .ser_outl (ser_outl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected register value, then
  // compare it (and both serial taps) just after the edge.
  task automatic cycle(input string tag, input logic r, input logic c, input logic [1:0] s,
                       input logic il, input logic ir, input logic [WIDTH-1:0] p,
                       input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] e;
    @(negedge clk);
    rst = r; ce = c; sel = s; ser_inl = il; ser_inr = ir; par_in = p;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_par"},  {28'd0, par_out}, {28'd0, e});
      check({tag, "_serr"}, {31'd0, ser_outr}, {31'd0, e[0]});
      check({tag, "_serl"}, {31'd0, ser_outl}, {31'd0, e[WIDTH-1]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] s;
    logic il, ir, r, c;
    logic [WIDTH-1:0] p;

    // Reset beats a simultaneous load
    cycle("rst",   1, 1, USR_LOAD, 0, 0, 4'hF, 4'b0000);
    // Shift left, serial in 1,0,1,1
    cycle("shl0",  0, 1, USR_SHL, 1, 0, 4'h0, 4'b0001);
    cycle("shl1",  0, 1, USR_SHL, 0, 1, 4'hF, 4'b0010);
    cycle("shl2",  0, 1, USR_SHL, 1, 0, 4'h0, 4'b0101);
    cycle("shl3",  0, 1, USR_SHL, 1, 0, 4'h0, 4'b1011);
    // Shift right from 1011 with ser_inr=1
    cycle("shr0",  0, 1, USR_SHR, 0, 1, 4'h0, 4'b1101);
    cycle("shr1",  0, 1, USR_SHR, 0, 1, 4'h0, 4'b1110);
    cycle("shr2",  0, 1, USR_SHR, 0, 1, 4'h0, 4'b1111);
    cycle("shr3",  0, 1, USR_SHR, 0, 1, 4'h0, 4'b1111);
    cycle("rst2",  1, 1, USR_SHR, 0, 1, 4'h0, 4'b0000);
    cycle("shrz0", 0, 1, USR_SHR, 0, 1, 4'h0, 4'b1000);
    cycle("shrz1", 0, 1, USR_SHR, 0, 1, 4'h0, 4'b1100);
    cycle("shrz2", 0, 1, USR_SHR, 0, 1, 4'h0, 4'b1110);
    cycle("shrz3", 0, 1, USR_SHR, 0, 1, 4'h0, 4'b1111);
    // Load then hold while serial inputs toggle
    cycle("ld0",   0, 1, USR_LOAD, 0, 0, 4'b0110, 4'b0110);
    for (int i = 0; i < 4; i++) begin
      cycle("hold", 0, 1, USR_HOLD, i[0], ~i[0], 4'b0000, 4'b0110);
    end
    cycle("ld1",   0, 1, USR_LOAD, 1, 1, 4'b1010, 4'b1010);
    // Reset mid-shift
    cycle("rm0",   1, 1, USR_HOLD, 0, 0, 4'h0, 4'b0000);
    cycle("rm1",   0, 1, USR_SHL, 1, 0, 4'h0, 4'b0001);
    cycle("rm2",   0, 1, USR_SHL, 0, 0, 4'h0, 4'b0010);
    cycle("rm3",   1, 1, USR_SHL, 1, 0, 4'h0, 4'b0000);
    cycle("rm4",   0, 1, USR_SHL, 1, 0, 4'h0, 4'b0001);
`ifdef USR_CE_EN
    cycle("ce_ld", 0, 1, USR_LOAD, 0, 0, 4'b1010, 4'b1010);
    for (int i = 0; i < 3; i++) begin
      cycle("ce_off", 0, 0, USR_SHR, 0, 1, 4'h0, 4'b1010);
    end
    cycle("ce_on", 0, 1, USR_SHR, 0, 0, 4'h0, 4'b0101);
    cycle("ce_rst", 1, 0, USR_LOAD, 0, 0, 4'hF, 4'b0000);
`endif

    // Random traffic against a behavioural model
    model = 4'b0000;
    cycle("rnd_rst", 1, 1, USR_HOLD, 0, 0, 4'h0, 4'b0000);
    for (int i = 0; i < 60; i++) begin
      s  = 2'($urandom_range(0, 3));
      il = 1'($urandom_range(0, 1));
      ir = 1'($urandom_range(0, 1));
      p  = 4'($urandom_range(0, 15));
      r  = ($urandom_range(0, 15) == 0);
`ifdef USR_CE_EN
      c  = ($urandom_range(0, 3) != 0);
`else
      c  = 1'b1;
`endif
      if (r)               model = 4'b0000;
      else if (!c)         model = model;
      else if (s == 2'd1)  model = {ir, model[3:1]};
      else if (s == 2'd2)  model = {model[2:0], il};
      else if (s == 2'd3)  model = p;
      cycle("rnd", r, c, s, il, ir, p, model);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
